// File: rtl/de_pipe_reg_pkg.sv
// Purpose: shared constants and helpers for the D->E pipeline register.
//   DW/TW          : datapath and Tnew counter widths
//   wd_sel_e       : MUX_regWD encodings (ALU, mem, link, ext)
//   TNEW_*         : cycles-until-result values per result source
//   tnew_lookup()  : Tnew assigned to an instruction as it enters E
package de_pipe_reg_pkg;

  localparam int DW = 32;
  localparam int TW = 2;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_LINK = 2'd2,
    WD_EXT  = 2'd3
  } wd_sel_e;

  localparam logic [TW-1:0] TNEW_NONE = 2'd0;
  localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW-1:0] TNEW_MEM  = 2'd2;

  // Link and ext results are already known in E, so they carry Tnew 0.
  // An instruction that does not write a register never needs forwarding.
  function automatic logic [TW-1:0] tnew_lookup(input logic regwe, input logic [1:0] wd);
    logic [TW-1:0] t;
    t = TNEW_NONE;
    if (regwe) begin
      case (wd_sel_e'(wd))
        WD_ALU:  t = TNEW_ALU;
        WD_MEM:  t = TNEW_MEM;
        default: t = TNEW_NONE;
      endcase
    end else begin
      t = TNEW_NONE;
    end
    return t;
  endfunction

endpackage

// File: rtl/de_pipe_reg_if.sv
// Purpose: bundle of the D-stage inputs, the hazard-unit controls (en, bubble)
// and the E-stage outputs of the D->E pipeline register.
//   master : drives en/bubble/d_*, observes e_*  (decoder side / bench)
//   slave  : the pipeline register itself
interface de_pipe_reg_if;
  import de_pipe_reg_pkg::*;

  logic          en;
  logic          bubble;
  logic [DW-1:0] d_pc;
  logic [DW-1:0] d_rs_data;
  logic [DW-1:0] d_rt_data;
  logic [DW-1:0] d_ext;
  logic          d_regWE;
  logic          d_memWE;
  logic          d_memMode;
  logic [1:0]    d_MUX_regWD;
  logic [1:0]    d_MUX_aluSrc;
  logic [2:0]    d_aluMode;
  logic [4:0]    d_regRA1;
  logic [4:0]    d_regRA2;
  logic [4:0]    d_regWA;

  logic [DW-1:0] e_pc;
  logic [DW-1:0] e_rs_data;
  logic [DW-1:0] e_rt_data;
  logic [DW-1:0] e_ext;
  logic          e_regWE;
  logic          e_memWE;
  logic          e_memMode;
  logic [1:0]    e_MUX_regWD;
  logic [1:0]    e_MUX_aluSrc;
  logic [2:0]    e_aluMode;
  logic [4:0]    e_regRA1;
  logic [4:0]    e_regRA2;
  logic [4:0]    e_regWA;
  logic [TW-1:0] e_tnew;
  logic [TW-1:0] e_tnew_m;
  logic          e_fwd_valid;
  logic [DW-1:0] e_fwd_data;

  modport master (
    output en, bubble, d_pc, d_rs_data, d_rt_data, d_ext, d_regWE, d_memWE,
           d_memMode, d_MUX_regWD, d_MUX_aluSrc, d_aluMode, d_regRA1, d_regRA2, d_regWA,
    input  e_pc, e_rs_data, e_rt_data, e_ext, e_regWE, e_memWE, e_memMode,
           e_MUX_regWD, e_MUX_aluSrc, e_aluMode, e_regRA1, e_regRA2, e_regWA,
           e_tnew, e_tnew_m, e_fwd_valid, e_fwd_data
  );

  modport slave (
    input  en, bubble, d_pc, d_rs_data, d_rt_data, d_ext, d_regWE, d_memWE,
           d_memMode, d_MUX_regWD, d_MUX_aluSrc, d_aluMode, d_regRA1, d_regRA2, d_regWA,
    output e_pc, e_rs_data, e_rt_data, e_ext, e_regWE, e_memWE, e_memMode,
           e_MUX_regWD, e_MUX_aluSrc, e_aluMode, e_regRA1, e_regRA2, e_regWA,
           e_tnew, e_tnew_m, e_fwd_valid, e_fwd_data
  );

endinterface

// File: rtl/de_pipe_reg_pipe_reg.sv
// Purpose: generic W-bit pipeline register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset to zero
//   i_clr : synchronous clear (bubble), beats i_en
//   i_en  : load i_d on this edge
//   i_d   : next value
//   o_q   : registered value
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Register with priority reset > clear > load > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/de_pipe_reg.sv
// Purpose: D->E pipeline register of the five-stage MIPS core. Captures the
// decoder bundle, operands, PC and immediate; tracks Tnew of the instruction in
// E and offers its result for forwarding when it is already known.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : de_pipe_reg_if.slave (en, bubble, d_* in; e_*, tnew, fwd out)
module de_pipe_reg
  import de_pipe_reg_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  de_pipe_reg_if.slave bus
);

  localparam int CW = 25 + TW;

  logic          w_regwe_cap;
  logic [TW-1:0] w_tnew_cap;
  logic [CW-1:0] w_ctrl_d;
  logic [CW-1:0] w_ctrl_q;
  logic [4*DW-1:0] w_data_d;
  logic [4*DW-1:0] w_data_q;

  logic [DW-1:0] w_pc_q;
  logic [DW-1:0] w_ext_q;
  logic          w_regwe_q;
  logic [1:0]    w_wd_q;
  logic [TW-1:0] w_tnew_q;
  logic [TW-1:0] w_tnew_m;
  logic          w_fwd_valid;
  logic [DW-1:0] w_fwd_data;

  // Writes to $0 are dropped at capture so nothing downstream ever forwards them.
  assign w_regwe_cap = bus.d_regWE & (bus.d_regWA != 5'd0);
  assign w_tnew_cap  = tnew_lookup(w_regwe_cap, bus.d_MUX_regWD);

  assign w_ctrl_d = {w_regwe_cap, bus.d_memWE, bus.d_memMode, bus.d_MUX_regWD,
                     bus.d_MUX_aluSrc, bus.d_aluMode, bus.d_regRA1, bus.d_regRA2,
                     bus.d_regWA, w_tnew_cap};
  assign w_data_d = {bus.d_pc, bus.d_rs_data, bus.d_rt_data, bus.d_ext};

  pipe_reg #(.W(CW)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.bubble),
    .i_en  (bus.en),
    .i_d   (w_ctrl_d),
    .o_q   (w_ctrl_q)
  );

  pipe_reg #(.W(4*DW)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.bubble),
    .i_en  (bus.en),
    .i_d   (w_data_d),
    .o_q   (w_data_q)
  );

  assign {w_regwe_q, bus.e_memWE, bus.e_memMode, w_wd_q, bus.e_MUX_aluSrc,
          bus.e_aluMode, bus.e_regRA1, bus.e_regRA2, bus.e_regWA, w_tnew_q} = w_ctrl_q;
  assign {w_pc_q, bus.e_rs_data, bus.e_rt_data, w_ext_q} = w_data_q;

  // Tnew seen by M one cycle later; saturates at zero instead of wrapping.
  always_comb begin
    w_tnew_m = '0;
    if (w_tnew_q == '0) begin
      w_tnew_m = '0;
    end else begin
      w_tnew_m = w_tnew_q - TW'(1);
    end
  end

  // Forward data depends only on registered state; PC+8 wraps modulo 2^DW.
  always_comb begin
    w_fwd_data = '0;
    case (wd_sel_e'(w_wd_q))
      WD_LINK: w_fwd_data = w_pc_q + 32'd8;
      WD_EXT:  w_fwd_data = w_ext_q;
      default: w_fwd_data = '0;
    endcase
  end

  assign w_fwd_valid = w_regwe_q & (w_tnew_q == TNEW_NONE);

  assign bus.e_pc        = w_pc_q;
  assign bus.e_ext       = w_ext_q;
  assign bus.e_regWE     = w_regwe_q;
  assign bus.e_MUX_regWD = w_wd_q;
  assign bus.e_tnew      = w_tnew_q;
  assign bus.e_tnew_m    = w_tnew_m;
  assign bus.e_fwd_valid = w_fwd_valid;
  assign bus.e_fwd_data  = w_fwd_data;

endmodule

// File: tb/tb_de_pipe_reg.sv
module tb_de_pipe_reg;
  import de_pipe_reg_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  de_pipe_reg_if bus();

  de_pipe_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model of the E-stage contents.
  logic [31:0] m_pc, m_rs, m_rt, m_ext;
  logic        m_we, m_mwe, m_mmode;
  logic [1:0]  m_wd, m_src;
  logic [2:0]  m_alu;
  logic [4:0]  m_ra1, m_ra2, m_wa;
  int          m_tnew;
  int          tnew_tab [4] = '{1, 2, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.bubble) begin
      m_pc <= 0; m_rs <= 0; m_rt <= 0; m_ext <= 0;
      m_we <= 0; m_mwe <= 0; m_mmode <= 0; m_wd <= 0; m_src <= 0; m_alu <= 0;
      m_ra1 <= 0; m_ra2 <= 0; m_wa <= 0; m_tnew <= 0;
    end else if (bus.en) begin
      m_pc <= bus.d_pc; m_rs <= bus.d_rs_data; m_rt <= bus.d_rt_data; m_ext <= bus.d_ext;
      m_we <= bus.d_regWE && (bus.d_regWA != 0);
      m_mwe <= bus.d_memWE; m_mmode <= bus.d_memMode; m_wd <= bus.d_MUX_regWD;
      m_src <= bus.d_MUX_aluSrc; m_alu <= bus.d_aluMode;
      m_ra1 <= bus.d_regRA1; m_ra2 <= bus.d_regRA2; m_wa <= bus.d_regWA;
      m_tnew <= (bus.d_regWE && bus.d_regWA != 0) ? tnew_tab[bus.d_MUX_regWD] : 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_fwd;
    int          exp_tm;
    exp_tm  = (m_tnew > 0) ? m_tnew - 1 : 0;
    exp_fwd = (m_wd == 2) ? m_pc + 32'd8 : ((m_wd == 3) ? m_ext : 32'd0);
    check("e_pc", bus.e_pc, m_pc);
    check("e_rs_data", bus.e_rs_data, m_rs);
    check("e_rt_data", bus.e_rt_data, m_rt);
    check("e_ext", bus.e_ext, m_ext);
    check("e_regWE", 32'(bus.e_regWE), 32'(m_we));
    check("e_memWE", 32'(bus.e_memWE), 32'(m_mwe));
    check("e_memMode", 32'(bus.e_memMode), 32'(m_mmode));
    check("e_MUX_regWD", 32'(bus.e_MUX_regWD), 32'(m_wd));
    check("e_MUX_aluSrc", 32'(bus.e_MUX_aluSrc), 32'(m_src));
    check("e_aluMode", 32'(bus.e_aluMode), 32'(m_alu));
    check("e_regRA1", 32'(bus.e_regRA1), 32'(m_ra1));
    check("e_regRA2", 32'(bus.e_regRA2), 32'(m_ra2));
    check("e_regWA", 32'(bus.e_regWA), 32'(m_wa));
    check("e_tnew", 32'(bus.e_tnew), 32'(m_tnew));
    check("e_tnew_m", 32'(bus.e_tnew_m), 32'(exp_tm));
    check("e_fwd_valid", 32'(bus.e_fwd_valid), 32'(m_we && m_tnew == 0));
    check("e_fwd_data", bus.e_fwd_data, exp_fwd);
  endtask

  // Per-cycle comparison on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (cmp_en) compare_all();
  end

  task automatic set_d(input logic [31:0] pc, rs, rt, ext, input logic we, mwe, mmode,
                       input logic [1:0] wd, src, input logic [2:0] alu,
                       input logic [4:0] ra1, ra2, wa, input logic en, bub);
    bus.d_pc = pc; bus.d_rs_data = rs; bus.d_rt_data = rt; bus.d_ext = ext;
    bus.d_regWE = we; bus.d_memWE = mwe; bus.d_memMode = mmode;
    bus.d_MUX_regWD = wd; bus.d_MUX_aluSrc = src; bus.d_aluMode = alu;
    bus.d_regRA1 = ra1; bus.d_regRA2 = ra2; bus.d_regWA = wa;
    bus.en = en; bus.bubble = bub;
  endtask

  task automatic rand_d(input logic en, bub);
    set_d($urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
          2'($urandom), 2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom_range(0, 3) == 0 ? 0 : $urandom), en, bub);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_d(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("rst_tnew", 32'(bus.e_tnew), 32'd0);
    check("rst_pc", bus.e_pc, 32'd0);
    check("rst_fwd_valid", 32'(bus.e_fwd_valid), 32'd0);
    step();
    rst_n = 1'b1;

    // 1: lw $8
    set_d(32'h0000_3000, 32'h10, 32'h20, 32'h4, 1, 0, 0, 2'd1, 2'd1, 3'd0, 5'd4, 5'd8, 5'd8, 1'b1, 1'b0);
    step();
    check("lw_tnew", 32'(bus.e_tnew), 32'd2);
    check("lw_tnew_m", 32'(bus.e_tnew_m), 32'd1);
    check("lw_fwd_valid", 32'(bus.e_fwd_valid), 32'd0);

    // 2: jal
    set_d(32'h0000_3000, 0, 0, 32'h0000_0c00, 1, 0, 0, 2'd2, 2'd0, 3'd0, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0);
    step();
    check("jal_tnew", 32'(bus.e_tnew), 32'd0);
    check("jal_fwd_valid", 32'(bus.e_fwd_valid), 32'd1);
    check("jal_fwd_data", bus.e_fwd_data, 32'h0000_3008);

    // jal at the top of the address space: PC+8 wraps
    set_d(32'hFFFF_FFFC, 0, 0, 0, 1, 0, 0, 2'd2, 2'd0, 3'd0, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0);
    step();
    check("jal_wrap", bus.e_fwd_data, 32'h0000_0004);

    // 3: addu $9 then hold for three edges with junk inputs
    set_d(32'h0000_3010, 32'h11, 32'h22, 0, 1, 0, 0, 2'd0, 2'd0, 3'd1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      rand_d(1'b0, 1'b0);
      step();
    end
    check("hold_tnew", 32'(bus.e_tnew), 32'd1);
    check("hold_regWA", 32'(bus.e_regWA), 32'd9);
    check("hold_rs", bus.e_rs_data, 32'h11);

    // 4: bubble beats en=1 and en=0
    set_d(32'h0000_3020, 1, 2, 3, 1, 0, 0, 2'd1, 2'd1, 3'd0, 5'd3, 5'd8, 5'd8, 1'b1, 1'b0);
    step();
    bus.bubble = 1'b1;
    step();
    check("bub_en1_pc", bus.e_pc, 32'd0);
    check("bub_en1_tnew", 32'(bus.e_tnew), 32'd0);
    check("bub_en1_fwd_valid", 32'(bus.e_fwd_valid), 32'd0);
    set_d(32'h0000_3024, 1, 2, 3, 1, 0, 0, 2'd1, 2'd1, 3'd0, 5'd3, 5'd8, 5'd8, 1'b1, 1'b0);
    step();
    bus.en = 1'b0;
    bus.bubble = 1'b1;
    step();
    check("bub_en0_regWA", 32'(bus.e_regWA), 32'd0);
    check("bub_en0_regWE", 32'(bus.e_regWE), 32'd0);

    // 5: lui into $0
    set_d(32'h0000_3030, 0, 0, 32'hABCD_0000, 1, 0, 0, 2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step();
    check("zero_regWE", 32'(bus.e_regWE), 32'd0);
    check("zero_fwd_valid", 32'(bus.e_fwd_valid), 32'd0);
    check("zero_ext", bus.e_ext, 32'hABCD_0000);

    // 6: async reset between edges while holding
    set_d(32'h0000_3040, 32'h55, 32'h66, 0, 1, 0, 0, 2'd0, 2'd0, 3'd1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    step();
    bus.en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_regWA", 32'(bus.e_regWA), 32'd0);
    check("arst_rs", bus.e_rs_data, 32'd0);
    check("arst_tnew", 32'(bus.e_tnew), 32'd0);
    compare_all();
    step();
    rst_n = 1'b1;
    set_d(32'h0000_3044, 7, 8, 0, 1, 0, 0, 2'd1, 2'd1, 3'd0, 5'd5, 5'd8, 5'd8, 1'b1, 1'b0);
    step();
    check("post_rst_pc", bus.e_pc, 32'h0000_3044);
    check("post_rst_tnew", 32'(bus.e_tnew), 32'd2);

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 40; i++) begin
      rand_d(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      step();
    end
    bus.en = 1'b0;
    bus.bubble = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
